// File: rtl/sysarr_pkg.sv
// Shared systolic-array definitions: default geometry and the partial-sum
// controller state encoding.
package sysarr_pkg;

  localparam int SYSARR_N     = 4;
  localparam int SYSARR_WIDTH = 16;
  localparam int ROWS_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  // Element countdown must hold 255 rows of n elements each.
  function automatic int elems_w(input int n);
    return ROWS_W + $clog2(n);
  endfunction

endpackage

// File: rtl/ps_fifo_ctrl.sv
// Partial-sum FIFO controller: loads rows into the upper half of a 2N-slot
// shift FIFO and streams the head element to the array, one job at a time.
module ps_fifo_ctrl
  import sysarr_pkg::*;
#(
  parameter int N     = SYSARR_N,
  parameter int WIDTH = SYSARR_WIDTH
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [ROWS_W-1:0]    num_rows,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_row,
  output logic                 fifo_load,
  output logic                 fifo_shift,
  output logic [N*WIDTH-1:0]   fifo_load_values,
  input  logic [WIDTH-1:0]     fifo_out,
  output logic                 ps_valid,
  input  logic                 ps_ready,
  output logic [WIDTH-1:0]     ps_data,
  output logic                 ps_last,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int EW = elems_w(N);
  localparam logic [2*N-1:0] UPPER_MASK = {{N{1'b1}}, {N{1'b0}}};

  ctrl_state_e         state_q, state_d;
  logic [2*N-1:0]      mask_q, mask_d;
  logic [ROWS_W-1:0]   rows_loaded_q, rows_loaded_d;
  logic [ROWS_W-1:0]   num_rows_q, num_rows_d;
  logic [EW-1:0]       elems_left_q, elems_left_d;
  logic                xfer;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      rows_loaded_q <= '0;
      num_rows_q    <= '0;
      elems_left_q  <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      rows_loaded_q <= rows_loaded_d;
      num_rows_q    <= num_rows_d;
      elems_left_q  <= elems_left_d;
    end
  end

  // Both ports use valid/ready: a beat moves on a rising edge where valid
  // and ready are both high; a producer holds its payload until then.
  always_comb begin
    in_ready   = (state_q == ST_RUN) && (mask_q[2*N-1:N] == '0) &&
                 (rows_loaded_q < num_rows_q);
    fifo_load  = in_valid && in_ready;
    ps_valid   = mask_q[0] && !fifo_load && (state_q == ST_RUN);
    xfer       = ps_valid && ps_ready;
    // A head-less but non-empty FIFO shifts on its own to close the gap.
    fifo_shift = !fifo_load && (xfer || (!mask_q[0] && (mask_q != '0)));
    ps_last    = (elems_left_q == EW'(1));
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    state_dbg  = state_q;
    fifo_load_values = in_row;
    ps_data          = fifo_out;
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    rows_loaded_d = rows_loaded_q;
    num_rows_d    = num_rows_q;
    elems_left_d  = elems_left_q;

    if (fifo_load) begin
      mask_d        = mask_q | UPPER_MASK;
      rows_loaded_d = rows_loaded_q + 8'd1;
    end else if (fifo_shift) begin
      mask_d = mask_q >> 1;
    end

    if (xfer) begin
      elems_left_d = elems_left_q - EW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_rows_d    = num_rows;
          rows_loaded_d = '0;
          elems_left_d  = EW'(num_rows) * EW'(N);
          state_d       = (num_rows != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (xfer && (elems_left_q == EW'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  a_load_shift_exclusive: assert property (
    @(posedge clk) disable iff (!nRST) !(fifo_load && fifo_shift));

  a_mask_empty_at_done: assert property (
    @(posedge clk) disable iff (!nRST) (state_q == ST_DONE) |-> (mask_q == '0));

endmodule

// File: tb/tb_ps_fifo_ctrl.sv
// Bench for ps_fifo_ctrl: a behavioural 2N-slot FIFO beside the controller and
// a scoreboard of expected head elements, with one task per scenario.
module tb_ps_fifo_ctrl;
  import sysarr_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           nRST;
  logic           start;
  logic [7:0]     num_rows;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_row;
  logic           fifo_load;
  logic           fifo_shift;
  logic [N*W-1:0] fifo_load_values;
  logic [W-1:0]   fifo_out;
  logic           ps_valid;
  logic           ps_ready;
  logic [W-1:0]   ps_data;
  logic           ps_last;
  logic           busy;
  logic           done;
  logic [1:0]     state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int loads = 0, shifts = 0, xfers = 0, dones = 0;
  int busy_cyc = 0, ir_cyc = 0, last_cnt = 0, cyc = 0;
  int last_xfer_cyc = -1, done_cyc = -1, job_cyc = 0;
  int row_idx = 0, row_base = 0, val_base = 0;

  ps_fifo_ctrl #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .nRST(nRST), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .fifo_load(fifo_load), .fifo_shift(fifo_shift),
    .fifo_load_values(fifo_load_values), .fifo_out(fifo_out),
    .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data),
    .ps_last(ps_last), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- partial-sum FIFO model ----------------
  logic [W-1:0] fifo_m [2*N];
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 2*N; i++) fifo_m[i] <= '0;
    end else if (fifo_load) begin
      for (int i = 0; i < N; i++) fifo_m[N+i] <= fifo_load_values[i*W +: W];
    end else if (fifo_shift) begin
      for (int i = 0; i < 2*N-1; i++) fifo_m[i] <= fifo_m[i+1];
      fifo_m[2*N-1] <= '0;
    end
  end
  assign fifo_out = fifo_m[0];

  // Loader: offers row (row_idx - row_base) of the current job
  always @(posedge clk) if (nRST && fifo_load) row_idx <= row_idx + 1;
  always_comb begin
    in_row = '0;
    for (int e = 0; e < N; e++)
      in_row[e*W +: W] = W'(val_base + (row_idx - row_base) * N + e + 1);
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic sb_cycle();
    logic [W-1:0] exp_v;
    logic exp_last;
    @(negedge clk);
    if (nRST) begin
      if (fifo_load) loads++;
      if (fifo_shift) shifts++;
      if (busy) busy_cyc++;
      if (in_ready) ir_cyc++;
      if (done) begin dones++; done_cyc = cyc; end
      checks++;
      if (fifo_load && fifo_shift) begin
        errors++;
        $display("FAIL load_shift_excl: cyc %0d load=%b shift=%b, required not both", cyc, fifo_load, fifo_shift);
      end
      if (ps_valid && ps_ready) begin
        xfers++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: cyc %0d got %h, required no transfer", cyc, ps_data);
        end else begin
          exp_v = exp_q.pop_front();
          exp_last = (exp_q.size() == 0);
          if (ps_data !== exp_v) begin
            errors++;
            $display("FAIL sb_data: cyc %0d got %h, required %h", cyc, ps_data, exp_v);
          end
          checks++;
          if (ps_last !== exp_last) begin
            errors++;
            $display("FAIL sb_last: cyc %0d got %b, required %b", cyc, ps_last, exp_last);
          end
        end
        if (ps_last) begin last_cnt++; last_xfer_cyc = cyc; end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_job(input int nrows, input int base);
    val_base = base;
    row_base = row_idx;
    for (int r = 0; r < nrows; r++)
      for (int e = 0; e < N; e++) exp_q.push_back(W'(base + r*N + e + 1));
    start = 1'b1;
    num_rows = 8'(nrows);
    job_cyc = cyc;
    sb_cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0, i;
    d0 = dones;
    i = 0;
    ok = 1'b0;
    while (!ok && i < budget) begin
      sb_cycle();
      if (dones != d0) ok = 1'b1;
      i++;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) sb_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST = 1'b0; start = 1'b0; num_rows = 8'd3; in_valid = 1'b1; ps_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, fifo_load, fifo_shift, ps_valid, ps_last, busy, done} !== 7'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b state %0d, required all 0 state 0",
               {in_ready, fifo_load, fifo_shift, ps_valid, ps_last, busy, done}, state_dbg);
    end
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    sb_cycle();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || loads != 0) begin
      errors++;
      $display("FAIL reset_idle: in_ready %b busy %b loads %0d, required 0 0 0", in_ready, busy, loads);
    end
  endtask

  task automatic test_basic();
    int l0, x0, lc0, b0;
    bit ok;
    in_valid = 1'b1; ps_ready = 1'b1;
    l0 = loads; x0 = xfers; lc0 = last_cnt; b0 = busy_cyc;
    start_job(2, 0);
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: no done within 100 cycles, required done"); end
    checks++;
    if (loads - l0 != 2) begin errors++; $display("FAIL basic_loads: got %0d, required 2", loads - l0); end
    checks++;
    if (xfers - x0 != 8) begin errors++; $display("FAIL basic_xfers: got %0d, required 8", xfers - x0); end
    checks++;
    if (last_cnt - lc0 != 1) begin errors++; $display("FAIL basic_last_count: got %0d, required 1", last_cnt - lc0); end
    checks++;
    if (done_cyc != last_xfer_cyc + 1) begin
      errors++; $display("FAIL basic_done_latency: done at %0d, required %0d", done_cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (done_cyc - job_cyc != 15) begin
      errors++; $display("FAIL basic_job_cycles: got %0d, required 15", done_cyc - job_cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_sb_empty: %0d left, required 0", exp_q.size()); end
    checks++;
    if (busy_cyc - b0 != 14) begin errors++; $display("FAIL basic_busy: got %0d cycles, required 14", busy_cyc - b0); end
    checks++;
    if (state_dbg !== 2'd0 || dut.mask_q !== '0) begin
      errors++; $display("FAIL basic_end_state: state %0d mask %b, required 0 0", state_dbg, dut.mask_q);
    end
    idle(2);
  endtask

  task automatic test_zero_rows();
    int l0, s0, d0, b0;
    in_valid = 1'b1; ps_ready = 1'b1;
    l0 = loads; s0 = shifts; d0 = dones; b0 = busy_cyc;
    start_job(0, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done_next: done %b busy %b, required 1 0", done, busy);
    end
    repeat (3) sb_cycle();
    checks++;
    if (dones - d0 != 1 || busy_cyc != b0) begin
      errors++; $display("FAIL zero_pulse: dones %0d busy cycles %0d, required 1 0", dones - d0, busy_cyc - b0);
    end
    checks++;
    if (loads != l0 || shifts != s0) begin
      errors++; $display("FAIL zero_no_fifo_ops: loads %0d shifts %0d, required 0 0", loads - l0, shifts - s0);
    end
    idle(1);
  endtask

  task automatic test_stall();
    int base, l0, s0, x0, i;
    bit ok;
    logic [W-1:0] held;
    base = $urandom_range(0, 16'h7000);
    held = W'(base + 1);
    in_valid = 1'b1; ps_ready = 1'b0;
    l0 = loads; x0 = xfers;
    start_job(2, base);
    i = 0;
    while (loads == l0 && i < 20) begin sb_cycle(); i++; end
    checks++;
    if (loads == l0) begin errors++; $display("FAIL stall_first_load: no load within 20 cycles, required 1"); end
    s0 = shifts;
    repeat (4) sb_cycle();
    checks++;
    if (shifts - s0 != 4) begin errors++; $display("FAIL stall_collapse: got %0d shifts, required 4", shifts - s0); end
    sb_cycle();
    checks++;
    if (loads - l0 != 2) begin errors++; $display("FAIL stall_second_load: got %0d, required 2", loads - l0); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({ps_valid, fifo_shift, in_ready} !== 3'b100 || ps_data !== held) begin
        errors++;
        $display("FAIL stall_hold: k %0d valid/shift/ready %b data %h, required 100 data %h",
                 k, {ps_valid, fifo_shift, in_ready}, ps_data, held);
      end
      sb_cycle();
    end
    checks++;
    if (xfers != x0) begin errors++; $display("FAIL stall_no_xfer: got %0d, required 0", xfers - x0); end
    ps_ready = 1'b1;
    wait_done(60, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || xfers - x0 != 8) begin
      errors++; $display("FAIL stall_finish: done %b left %0d xfers %0d, required 1 0 8", ok, exp_q.size(), xfers - x0);
    end
    idle(2);
  endtask

  task automatic test_one_row();
    int l0, x0, ir0;
    bit ok;
    in_valid = 1'b1; ps_ready = 1'b1;
    l0 = loads; x0 = xfers; ir0 = ir_cyc;
    start_job(1, $urandom_range(0, 16'hF000));
    wait_done(60, ok);
    repeat (3) sb_cycle();
    checks++;
    if (!ok || xfers - x0 != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL one_row_finish: done %b xfers %0d left %0d, required 1 4 0", ok, xfers - x0, exp_q.size());
    end
    checks++;
    if (loads - l0 != 1) begin errors++; $display("FAIL one_row_loads: got %0d, required 1", loads - l0); end
    checks++;
    if (ir_cyc - ir0 != 1) begin errors++; $display("FAIL one_row_ready: got %0d ready cycles, required 1", ir_cyc - ir0); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int x0, l0, i;
    bit ok;
    in_valid = 1'b1; ps_ready = 1'b1;
    x0 = xfers;
    start_job(3, $urandom_range(0, 16'h8000));
    i = 0;
    while (xfers - x0 < 3 && i < 40) begin sb_cycle(); i++; end
    checks++;
    if (xfers - x0 != 3) begin errors++; $display("FAIL rst_mid_reach: got %0d xfers, required 3", xfers - x0); end
    nRST = 1'b0;
    #1;
    checks++;
    if ({in_ready, fifo_load, fifo_shift, ps_valid, ps_last, busy, done} !== 7'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b state %0d, required all 0 state 0",
               {in_ready, fifo_load, fifo_shift, ps_valid, ps_last, busy, done}, state_dbg);
    end
    checks++;
    if (dut.mask_q !== '0 || dut.rows_loaded_q !== '0 || dut.elems_left_q !== '0 || dut.num_rows_q !== '0) begin
      errors++;
      $display("FAIL rst_mid_regs: mask %b rows %0d elems %0d num %0d, required all 0",
               dut.mask_q, dut.rows_loaded_q, dut.elems_left_q, dut.num_rows_q);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    l0 = loads; x0 = xfers;
    start_job(1, $urandom_range(0, 16'h8000));
    wait_done(60, ok);
    checks++;
    if (!ok || loads - l0 != 1 || xfers - x0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_next_job: done %b loads %0d xfers %0d left %0d, required 1 1 4 0",
               ok, loads - l0, xfers - x0, exp_q.size());
    end
    idle(1);
  endtask

  task automatic test_start_in_run();
    int x0, l0, d0, i;
    bit ok;
    in_valid = 1'b1; ps_ready = 1'b1;
    x0 = xfers; l0 = loads; d0 = dones;
    start_job(2, $urandom_range(0, 16'h8000));
    i = 0;
    while (xfers - x0 < 2 && i < 40) begin sb_cycle(); i++; end
    start = 1'b1;
    num_rows = 8'd7;
    sb_cycle();
    start = 1'b0;
    checks++;
    if (dut.num_rows_q !== 8'd2 || int'(dut.elems_left_q) != 8 - (xfers - x0) || state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL run_start_ignored: num %0d elems %0d state %0d, required 2 %0d 1",
               dut.num_rows_q, dut.elems_left_q, state_dbg, 8 - (xfers - x0));
    end
    wait_done(60, ok);
    repeat (2) sb_cycle();
    checks++;
    if (!ok || loads - l0 != 2 || xfers - x0 != 8 || dones - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_start_finish: done %b loads %0d xfers %0d dones %0d, required 1 2 8 1",
               ok, loads - l0, xfers - x0, dones - d0);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int n, l0, i;
    bit ok;
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 5);
      l0 = loads;
      in_valid = 1'b1;
      start_job(n, $urandom_range(0, 16'hC000));
      ok = 1'b0;
      i = 0;
      while (!ok && i < 400) begin
        in_valid = 1'($urandom_range(0, 1));
        ps_ready = ($urandom_range(0, 3) != 0);
        sb_cycle();
        if (done_cyc == cyc - 1) ok = 1'b1;
        i++;
      end
      checks++;
      if (!ok || loads - l0 != n || exp_q.size() != 0) begin
        errors++;
        $display("FAIL b2b_job%0d: done %b loads %0d left %0d, required 1 %0d 0", j, ok, loads - l0, exp_q.size(), n);
      end
    end
    ps_ready = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_stall();
    test_one_row();
    test_reset_mid();
    test_start_in_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps_fifo_ctrl.md
PS_FIFO_CTRL -- requirements
Module: ps_fifo_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning partial sums per array row.
REQ-002 SHALL have parameter WIDTH, default 16, meaning bits per partial sum.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-006 SHALL have port num_rows  in  8  rows in the job; captured when start is accepted.
REQ-007 SHALL have port in_valid  in  1  loader offers a partial-sum row.
REQ-008 SHALL have port in_ready  out  1  controller accepts the row this cycle.
REQ-009 SHALL have port in_row  in  N*WIDTH  offered row; element 0 in bits WIDTH-1:0.
REQ-010 SHALL have port fifo_load  out  1  write in_row into the FIFO upper half.
REQ-011 SHALL have port fifo_shift  out  1  shift the FIFO by one element toward the output.
REQ-012 SHALL have port fifo_load_values  out  N*WIDTH  equal to in_row, combinational.
REQ-013 SHALL have port fifo_out  in  WIDTH  FIFO head element.
REQ-014 SHALL have port ps_valid  out  1  head partial sum offered to the array.
REQ-015 SHALL have port ps_ready  in  1  array consumes the head this cycle.
REQ-016 SHALL have port ps_data  out  WIDTH  equal to fifo_out, combinational.
REQ-017 SHALL have port ps_last  out  1  qualifies ps_valid; high on the final element of the job.
REQ-018 SHALL have port busy  out  1  high in RUN.
REQ-019 SHALL have port done  out  1  one-cycle pulse at job completion.

Function
REQ-020 SHALL implement the states IDLE, RUN and DONE: IDLE goes to RUN on start with num_rows>0; IDLE goes to DONE on start with num_rows==0; RUN goes to DONE in the cycle after the final element transfer; DONE always goes to IDLE.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL keep a 2N-bit occupancy mask mirroring the FIFO slots: a load sets bits 2N-1:N, a shift moves the mask right by one, and bit 0 is the head-valid.
REQ-023 SHALL assert in_ready only in RUN, with mask[2N-1:N]==0 and rows_loaded<num_rows_q.
REQ-024 SHALL assert fifo_load iff in_valid && in_ready, and SHALL increment rows_loaded on each load.
REQ-025 SHALL never assert fifo_load and fifo_shift in the same cycle, with load taking priority.
REQ-026 SHALL, when no load occurs, assert fifo_shift if (mask[0] && ps_ready && ps_valid), or if (!mask[0] && mask!=0) to collapse a bubble.
REQ-027 SHALL drive ps_valid = mask[0] && !fifo_load && state==RUN, so the array stalls for one cycle per load; N=4 sustains 4 of every 5 cycles.
REQ-028 SHALL count down elems_left, width 8+clog2(N), from num_rows*N by one per transfer, and SHALL drive ps_last = (elems_left==1).
REQ-029 SHALL drop rows offered beyond num_rows_q by holding in_ready low, and SHALL never consume those rows.
REQ-030 SHALL accept no new rows in DONE or IDLE, and SHALL hold the mask at zero at the end of every job.

Reset
REQ-031 SHALL, on nRST low at any time including mid-job, clear the state to IDLE, the mask, rows_loaded, elems_left and num_rows_q to 0.
REQ-032 SHALL force in_ready, fifo_load, fifo_shift, ps_valid, ps_last, busy and done to 0 while nRST is low; the FIFO is reset by the same nRST.

Structure
REQ-033 SHALL take the state enum (IDLE/RUN/DONE) and the defaults N=4 and WIDTH=16 from the shared sysarr_pkg package.
REQ-034 SHALL be a single module with no sub-module, instantiated beside the partial-sum FIFO in the array top level.

Verification (N=4, WIDTH=16)
REQ-035 SHALL be verified with num_rows=2, in_valid always high and ps_ready always high: 2 loads, 8 transfers of 0x0001..0x0008 in order, ps_last on 0x0008 only, and done 1 cycle after the transfer.
REQ-036 SHALL be verified with start and num_rows=0: done pulses the next cycle, busy is never high, and no load or shift occurs.
REQ-037 SHALL be verified with ps_ready low for 10 cycles after the first load: after the bubble collapse, ps_valid is held with ps_data stable and no shift, and in_ready stays low while the upper mask is occupied.
REQ-038 SHALL be verified with num_rows=1 and in_valid held after the first load: exactly 1 load, and in_ready stays 0 thereafter.
REQ-039 SHALL be verified with nRST pulsed low after the third transfer of a 3-row job: all outputs are 0 immediately, and a subsequent 1-row job completes normally.
REQ-040 SHALL be verified with start pulsed during RUN: it is ignored, and elems_left and num_rows_q are unchanged.
